pipe_mem_stage: RTL
===================

PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all stage registers and memory writes.
REQ-002 SHALL have port: clrn  input  1  reset; asynchronous, active-high (clrn=1 resets).
REQ-003 SHALL have port: ewreg  input  1  EXE-stage register-write enable.
REQ-004 SHALL have port: em2reg  input  1  EXE-stage select memory data for writeback.
REQ-005 SHALL have port: ewmem  input  1  EXE-stage memory-write enable.
REQ-006 SHALL have port: ealu  input  32  EXE ALU result, used as byte address or writeback value.
REQ-007 SHALL have port: eb  input  32  EXE store data.
REQ-008 SHALL have port: ern  input  5  EXE destination register number.
REQ-009 SHALL have ports: mwreg, mm2reg, mwmem (1), malu, mb (32), mrn (5)  outputs  EXE/MEM register contents, exposed for forwarding.
REQ-010 SHALL have ports: wwreg, wm2reg (1), wmo, walu (32), wrn (5)  outputs  MEM/WB register contents.
REQ-011 SHALL have port: mmisalign  output  1  misaligned access flag for the current MEM-stage instruction.
REQ-012 SHALL have parameter: AW, default 8, word-address width; memory depth 2^AW words of 32 bits.

Function
REQ-013 SHALL capture ewreg, em2reg, ewmem, ealu, eb, ern into mwreg, mm2reg, mwmem, malu, mb, mrn on each rising clk edge while clrn=0.
REQ-014 SHALL capture mwreg, mm2reg, mmo, malu, mrn into wwreg, wm2reg, wmo, walu, wrn on each rising clk edge while clrn=0.
REQ-015 SHALL index memory with word address malu[AW+1:2]; malu bits above AW+1 ignored (address wraps modulo 2^AW words).
REQ-016 SHALL read memory combinationally: mmo = mem[malu[AW+1:2]], valid in the same cycle as the MEM-stage instruction.
REQ-017 SHALL write mb to mem[malu[AW+1:2]] on the rising clk edge when mwmem=1, clrn=0, and the write is not suppressed (REQ-027).
REQ-018 SHALL give latency: inputs sampled at edge k appear on m* after edge k; load data appears on wmo after edge k+1.
REQ-019 SHALL make a store written at edge k visible to a load whose MEM cycle starts at edge k (back-to-back store then load, same address, returns the new value).
REQ-020 SHALL, when mwmem=1 and mm2reg=1 together, perform the write and capture the pre-write (old) word into wmo.
REQ-021 SHALL not alter memory when mwmem=0, whatever malu and mb hold.
REQ-022 SHALL zero-initialise all memory words at simulation time 0; memory has no reset.

Reset
REQ-023 SHALL, while clrn=1, force all m* and w* register outputs to 0 immediately, independent of clk.
REQ-024 SHALL suppress any memory write while clrn=1, including a write pending in the MEM stage when reset asserts mid-operation; memory contents are retained.
REQ-025 SHALL resume normal capture on the first rising clk edge after clrn returns to 0.

Configuration
REQ-026 SHALL compile misalignment checking in only when macro PIPE_MEM_MISALIGN_CHECK_EN is defined.
REQ-027 SHALL, with PIPE_MEM_MISALIGN_CHECK_EN defined, set mmisalign=1 when (mwmem|mm2reg)=1 and malu[1:0]!=0, suppress the memory write, and capture wwreg=0 for that instruction.
REQ-028 SHALL, without PIPE_MEM_MISALIGN_CHECK_EN, tie mmisalign to 0 and ignore malu[1:0].

Verification
REQ-029 SHALL cover: store ewmem=1, ealu=0x10, eb=0xDEADBEEF, then load em2reg=1, ewreg=1, ealu=0x10, ern=5 -> wmo=0xDEADBEEF, wrn=5, wwreg=1 two edges after the load is presented.
REQ-030 SHALL cover: ALU op ewreg=1, em2reg=0, ealu=0x1234, ern=3 -> malu=0x1234 after edge 1; walu=0x1234, wrn=3, wm2reg=0 after edge 2; memory unchanged.
REQ-031 SHALL cover: store pending in MEM (mwmem=1, malu=0x20, mb=0x55), clrn pulsed to 1 before the edge -> mem word 8 remains 0; all m*/w* outputs read 0.
REQ-032 SHALL cover: store to ealu=0x400 with AW=8 -> word 0 written (wrap); load from 0x0 returns the stored value.
REQ-033 SHALL cover (macro defined): store ealu=0x13, eb=0x1 -> mmisalign=1, mem word 4 unchanged; load ealu=0x12, ewreg=1 -> wwreg=0. Macro undefined: same store writes word 4, mmisalign=0.

Source files
------------

// File: rtl/pipe_mem_stage.sv
// MEM stage of a 5-stage pipeline: EXE/MEM and MEM/WB registers around a word-addressed data memory.
// Optional misalignment check is built when PIPE_MEM_MISALIGN_CHECK_EN is defined.
module pipe_mem_stage #(
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [31:0] malu,
    output logic [31:0] mb,
    output logic [4:0]  mrn,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic        mmisalign
);

    logic        mwreg_q, mm2reg_q, mwmem_q;
    logic [31:0] malu_q, mb_q;
    logic [4:0]  mrn_q;
    logic        mwreg_d, mm2reg_d, mwmem_d;
    logic [31:0] malu_d, mb_d;
    logic [4:0]  mrn_d;

    logic        wwreg_q, wm2reg_q;
    logic [31:0] wmo_q, walu_q;
    logic [4:0]  wrn_q;
    logic        wwreg_d, wm2reg_d;
    logic [31:0] wmo_d, walu_d;
    logic [4:0]  wrn_d;

    logic [31:0]   mem [0:(1<<AW)-1] = '{default: '0};
    logic [AW-1:0] widx;
    logic [31:0]   mmo;
    logic          mis;
    logic          mem_we;

    // EXE/MEM boundary
    always_comb begin
        mwreg_d  = ewreg;
        mm2reg_d = em2reg;
        mwmem_d  = ewmem;
        malu_d   = ealu;
        mb_d     = eb;
        mrn_d    = ern;
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            malu_q   <= '0;
            mb_q     <= '0;
            mrn_q    <= '0;
        end else begin
            mwreg_q  <= mwreg_d;
            mm2reg_q <= mm2reg_d;
            mwmem_q  <= mwmem_d;
            malu_q   <= malu_d;
            mb_q     <= mb_d;
            mrn_q    <= mrn_d;
        end
    end

    // MEM stage: byte address bits above the word index simply wrap
    assign widx = malu_q[AW+1:2];
    assign mmo  = mem[widx];

`ifdef PIPE_MEM_MISALIGN_CHECK_EN
    assign mis = (mwmem_q | mm2reg_q) & (malu_q[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign mmisalign = mis;

    // clrn gates the write so a store caught in MEM during reset never lands
    assign mem_we = mwmem_q & ~clrn & ~mis;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[widx] <= mb_q;
        end
    end

    // MEM/WB boundary: wmo takes the pre-write word when a store and load coincide
    always_comb begin
        wwreg_d  = mwreg_q & ~mis;
        wm2reg_d = mm2reg_q;
        wmo_d    = mmo;
        walu_d   = malu_q;
        wrn_d    = mrn_q;
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
            wmo_q    <= '0;
            walu_q   <= '0;
            wrn_q    <= '0;
        end else begin
            wwreg_q  <= wwreg_d;
            wm2reg_q <= wm2reg_d;
            wmo_q    <= wmo_d;
            walu_q   <= walu_d;
            wrn_q    <= wrn_d;
        end
    end

    assign mwreg  = mwreg_q;
    assign mm2reg = mm2reg_q;
    assign mwmem  = mwmem_q;
    assign malu   = malu_q;
    assign mb     = mb_q;
    assign mrn    = mrn_q;
    assign wwreg  = wwreg_q;
    assign wm2reg = wm2reg_q;
    assign wmo    = wmo_q;
    assign walu   = walu_q;
    assign wrn    = wrn_q;

endmodule
